// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone memory responder:
//   - bus widths (address, data, nibble-select)
//   - responder FSM state type
//   - nibble_mask(): expands a 4-bit nibble select into a 16-bit bit mask
// No ports (package).
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_ADR_W = 16;
    localparam int WB_DAT_W = 16;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_resp_state_t;

    // sel[i] covers data bits [4i+3:4i].
    function automatic logic [WB_DAT_W-1:0] nibble_mask(input logic [WB_SEL_W-1:0] sel);
        logic [WB_DAT_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < WB_SEL_W; i++) begin
            mask[4*i +: 4] = {4{sel[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_mem_array.sv
// -----------------------------------------------------------------------------
// wb_mem_array
// Flop-based word storage for the Wishbone responder.
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high clear of every word
//   wr_en    in   write strobe
//   wr_idx   in   write word index
//   wr_data  in   write data
//   wr_mask  in   per-bit write enable (1 = update that bit)
//   rd_idx   in   read word index
//   rd_data  out  combinational read data
// -----------------------------------------------------------------------------
module wb_mem_array
    import wb_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_idx,
    input  logic [WB_DAT_W-1:0] wr_data,
    input  logic [WB_DAT_W-1:0] wr_mask,
    input  logic [AW-1:0]       rd_idx,
    output logic [WB_DAT_W-1:0] rd_data
);

    logic [WB_DAT_W-1:0] mem [DEPTH];

    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    // NOTE: the storage is cleared by reset on purpose (the memory must read
    // back as zero after reset), so it is built from flops rather than a RAM
    // macro, which could not be cleared in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/wb_mem_responder.sv
// -----------------------------------------------------------------------------
// wb_mem_responder
// Wishbone slave with a base-address window, DEPTH x 16-bit flop memory and a
// fixed number of wait states between accept and a one-cycle ack.
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset (FSM, outputs and memory)
//   cyc_in    in   master cycle request, doubles as strobe
//   we        in   0 = read, 1 = write
//   adr_in    in   word address
//   data_in   in   write data
//   sel_in    in   nibble enables, sel_in[i] -> data[4i+3:4i]
//   data_out  out  read data, zero unless acking a read
//   ack_out   out  one-cycle transfer-complete strobe
// -----------------------------------------------------------------------------
module wb_mem_responder
    import wb_pkg::*;
#(
    parameter int                  DEPTH       = 64,
    parameter logic [WB_ADR_W-1:0] BASE        = 16'h0000,
    parameter int                  WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cyc_in,
    input  logic                we,
    input  logic [WB_ADR_W-1:0] adr_in,
    input  logic [WB_DAT_W-1:0] data_in,
    input  logic [WB_SEL_W-1:0] sel_in,
    output logic [WB_DAT_W-1:0] data_out,
    output logic                ack_out
);

    localparam int AW = $clog2(DEPTH);

    wb_resp_state_t      state;
    logic [3:0]          cnt;

    // Request captured at accept time; the master may change its inputs
    // once the transfer is in flight.
    logic [AW-1:0]       lat_idx;
    logic                lat_we;
    logic [WB_DAT_W-1:0] lat_data;
    logic [WB_SEL_W-1:0] lat_sel;

    logic                hit;
    logic                accept;
    logic                enter_ack;
    logic [AW-1:0]       rd_idx;
    logic                ack_we;
    logic [WB_SEL_W-1:0] ack_sel;
    logic [WB_DAT_W-1:0] rd_word;
    logic                wr_en;

    assign hit    = (adr_in[WB_ADR_W-1:AW] == BASE[WB_ADR_W-1:AW]);
    assign accept = (state == IDLE) && cyc_in && hit;

    // The ack register is loaded on the edge that enters ACK, so ack_out and
    // data_out are flop outputs with no path from the bus inputs.
    assign enter_ack = (accept && (WAIT_STATES == 0)) ||
                       ((state == WAIT) && cyc_in && (cnt == 4'd0));

    // Read-data source for the transfer about to be acked: the live inputs
    // when acking straight out of IDLE, otherwise the latched request.
    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    always_comb begin
        rd_idx  = lat_idx;
        ack_we  = lat_we;
        ack_sel = lat_sel;
        if (state == IDLE) begin
            rd_idx  = adr_in[AW-1:0];
            ack_we  = we;
            ack_sel = sel_in;
        end
    end

    // The write commits on the edge that leaves ACK, so a read accepted in the
    // following IDLE cycle already sees the new word.
    assign wr_en = (state == ACK) && lat_we;

    wb_mem_array #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_idx  (lat_idx),
        .wr_data (lat_data),
        .wr_mask (nibble_mask(lat_sel)),
        .rd_idx  (rd_idx),
        .rd_data (rd_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            lat_idx  <= '0;
            lat_we   <= 1'b0;
            lat_data <= '0;
            lat_sel  <= '0;
            ack_out  <= 1'b0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_idx  <= adr_in[AW-1:0];
                        lat_we   <= we;
                        lat_data <= data_in;
                        lat_sel  <= sel_in;
                        if (WAIT_STATES == 0) begin
                            state <= ACK;
                            cnt   <= 4'd0;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    // A dropped cycle wins over an expiring count: abort
                    // with no write and no ack.
                    if (!cyc_in) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd0) begin
                        state <= ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase

            ack_out  <= enter_ack;
            data_out <= (enter_ack && !ack_we) ? (rd_word & nibble_mask(ack_sel))
                                               : '0;
        end
    end

endmodule

// File: tb/tb_wb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_wb_mem_responder
// Two responders share one clock: d0 (BASE 0x0000, no wait states) and
// d1 (BASE 0x0100, 3 wait states), both 64 words. Expected read data comes
// from an array model of each memory and is queued when a request is issued;
// a monitor pops and compares on every ack and checks data_out is 0 otherwise.
// -----------------------------------------------------------------------------
module tb_wb_mem_responder;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        cyc   [2];
    logic        we_s  [2];
    logic [15:0] adr   [2];
    logic [15:0] wdat  [2];
    logic [3:0]  sel   [2];
    logic [15:0] rdat  [2];
    logic        ack   [2];

    always #5 clk = ~clk;

    wb_mem_responder #(.DEPTH(64), .BASE(16'h0000), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst[0]), .cyc_in(cyc[0]), .we(we_s[0]), .adr_in(adr[0]),
        .data_in(wdat[0]), .sel_in(sel[0]), .data_out(rdat[0]), .ack_out(ack[0])
    );

    wb_mem_responder #(.DEPTH(64), .BASE(16'h0100), .WAIT_STATES(3)) dut1 (
        .clk(clk), .reset(rst[1]), .cyc_in(cyc[1]), .we(we_s[1]), .adr_in(adr[1]),
        .data_in(wdat[1]), .sel_in(sel[1]), .data_out(rdat[1]), .ack_out(ack[1])
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] model [2][64];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic        prev_ack [2];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [15:0] bit_mask(input logic [3:0] s);
        logic [15:0] m;
        m = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) m = m | (16'hF << (4 * i));
        end
        return m;
    endfunction

    // Full transfer on responder d; returns at posedge+1 after the ack cycle.
    // With hold = 1 cyc stays high so the next call is a back-to-back transfer.
    task automatic xfer(input int d, input logic w, input logic [15:0] a,
                        input logic [15:0] dat, input logic [3:0] s, input bit hold);
        int          n;
        logic [15:0] m;
        logic [15:0] exp;
        m = bit_mask(s);
        if (w) begin
            exp = 16'h0000;
            model[d][a[5:0]] = (model[d][a[5:0]] & ~m) | (dat & m);
        end else begin
            exp = model[d][a[5:0]] & m;
        end
        if (d == 0) q0.push_back(exp); else q1.push_back(exp);
        cyc[d] = 1'b1; we_s[d] = w; adr[d] = a; wdat[d] = dat; sel[d] = s;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (ack[d]) break;
        end
        check($sformatf("ack_latency_d%0d", d), 16'(n), 16'(ws_of(d) + 2));
        if (n >= 40) begin
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        @(posedge clk); #1;
        if (!hold) cyc[d] = 1'b0;
    endtask

    // Request outside the window held for n cycles: must never be acked.
    task automatic miss(input int d, input logic [15:0] a, input int ncyc);
        int acks;
        acks = 0;
        cyc[d] = 1'b1; we_s[d] = 1'b0; adr[d] = a; sel[d] = 4'hF;
        repeat (ncyc) begin
            @(negedge clk);
            if (ack[d]) acks++;
        end
        check($sformatf("miss_no_ack_d%0d", d), 16'(acks), 16'd0);
        @(posedge clk); #1;
        cyc[d] = 1'b0;
    endtask

    // Write on d1 interrupted two edges after issue, either by dropping cyc
    // or by reset; with_reset also clears the model.
    task automatic abort_write(input logic [15:0] a, input logic [15:0] dat, input bit with_reset);
        int acks;
        acks = 0;
        cyc[1] = 1'b1; we_s[1] = 1'b1; adr[1] = a; wdat[1] = dat; sel[1] = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        cyc[1] = 1'b0;
        if (with_reset) begin
            rst[1] = 1'b1;
            @(posedge clk); #1;
            rst[1] = 1'b0;
            for (int i = 0; i < 64; i++) model[1][i] = 16'h0000;
        end
        repeat (8) begin
            @(negedge clk);
            if (ack[1]) acks++;
        end
        check(with_reset ? "reset_abort_no_ack" : "abort_no_ack", 16'(acks), 16'd0);
        @(posedge clk); #1;
    endtask

    task automatic monitor_step();
        logic [15:0] exp;
        for (int d = 0; d < 2; d++) begin
            if (ack[d]) begin
                check($sformatf("ack_width_d%0d", d), 16'(prev_ack[d]), 16'd0);
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    check($sformatf("ack_unexpected_d%0d", d), 16'(ack[d]), 16'd0);
                end else begin
                    exp = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("data_d%0d", d), rdat[d], exp);
                end
            end else begin
                check($sformatf("data_hold_d%0d", d), rdat[d], 16'h0000);
            end
            prev_ack[d] = ack[d];
        end
    endtask

    task automatic stimulus();
        logic [15:0] a;
        logic [5:0]  idx;
        bit          h;
        // d0: zero wait states
        xfer(0, 1'b0, 16'h0005, 16'h0000, 4'hF, 1'b0);
        xfer(0, 1'b1, 16'h0003, 16'hA5C3, 4'hF, 1'b0);
        xfer(0, 1'b0, 16'h0003, 16'h0000, 4'hF, 1'b0);
        xfer(0, 1'b1, 16'h0007, 16'h1234, 4'hF, 1'b0);
        xfer(0, 1'b1, 16'h0007, 16'hFFFF, 4'b0101, 1'b1);
        xfer(0, 1'b0, 16'h0007, 16'h0000, 4'hF, 1'b0);   // back-to-back RAW -> 1F3F
        xfer(0, 1'b0, 16'h0007, 16'h0000, 4'b1010, 1'b0); // unselected nibbles -> 1030
        // d1: three wait states, base 0x0100
        xfer(1, 1'b0, 16'h0105, 16'h0000, 4'hF, 1'b0);
        xfer(1, 1'b1, 16'h0105, 16'h1111, 4'hF, 1'b0);
        abort_write(16'h0105, 16'hBEEF, 1'b0);
        xfer(1, 1'b0, 16'h0105, 16'h0000, 4'hF, 1'b0);   // old value 1111
        abort_write(16'h0106, 16'hBEEF, 1'b1);
        xfer(1, 1'b0, 16'h0105, 16'h0000, 4'hF, 1'b0);   // cleared by reset
        xfer(1, 1'b0, 16'h0106, 16'h0000, 4'hF, 1'b0);
        miss(1, 16'h0200, 20);
        xfer(1, 1'b1, 16'h013F, 16'hC0DE, 4'hF, 1'b1);
        xfer(1, 1'b0, 16'h013F, 16'h0000, 4'hF, 1'b0);
        // randomized traffic on both responders
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 150; k++) begin
                idx = 6'($urandom_range(0, 15));
                if (k % 10 == 9) idx = 6'($urandom_range(0, 63));
                a = (d == 0) ? {10'h000, idx} : {10'h004, idx};
                if (d == 1 && $urandom_range(0, 19) == 0) begin
                    a = 16'($urandom);
                    if (a[15:6] == 10'h004) a[15] = 1'b1;
                    miss(1, a, 6);
                end else begin
                    h = (k != 149) && ($urandom_range(0, 2) == 0);
                    xfer(d, 1'($urandom_range(0, 1)), a, 16'($urandom),
                         4'($urandom_range(0, 15)), h);
                end
            end
            cyc[d] = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        repeat (4) @(negedge clk);
        check("queue0_drained", 16'(q0.size()), 16'd0);
        check("queue1_drained", 16'(q1.size()), 16'd0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; cyc[d] = 1'b0; we_s[d] = 1'b0; adr[d] = '0;
            wdat[d] = '0; sel[d] = '0; prev_ack[d] = 1'b0;
            for (int i = 0; i < 64; i++) model[d][i] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_ack_d%0d", d), 16'(ack[d]), 16'd0);
            check($sformatf("reset_data_d%0d", d), rdat[d], 16'h0000);
        end
        @(posedge clk); #1;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            stimulus();
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/wb_mem_responder.md
# wb_mem_responder

Wishbone responder (slave end) for the CPU bus: decodes a base-address window, holds a flop-based memory of `DEPTH` 16-bit words, and answers each master cycle with a one-cycle `ack_out` after a fixed number of wait states. It is the memory-side peer of the CPU Wishbone initiator. It serves as the testbench memory model and as the on-chip scratch RAM.

## Interface
Parameters:
- `DEPTH`, 64: number of 16-bit words; power of two, 2..1024.
- `BASE`, 16'h0000: window base; must be aligned to `DEPTH`.
- `WAIT_STATES`, 0: idle cycles inserted between accept and ack; 0..15.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cyc_in`  in  1  master cycle request; also acts as strobe.
- `we`  in  1  0 = read, 1 = write.
- `adr_in`  in  16  word address from master.
- `data_in`  in  16  write data from master.
- `sel_in`  in  4  nibble enables; `sel_in[i]` enables `data[4i+3:4i]`.
- `data_out`  out  16  read data; valid only while `ack_out` = 1.
- `ack_out`  out  1  transfer-complete strobe, one cycle.

## Operation
- Hit: `adr_in[15:AW] == BASE[15:AW]`, where AW = log2(`DEPTH`). Index = `adr_in[AW-1:0]`.
- FSM states:
  - IDLE: if `cyc_in` && hit, latch `adr`/`we`/`data_in`/`sel_in` and go to WAIT, or to ACK if `WAIT_STATES` = 0. If `cyc_in` && !hit, stay in IDLE and never ack; another decoder owns that address.
  - WAIT: decrement a counter loaded with `WAIT_STATES`-1. When it reaches 0, go to ACK. If `cyc_in` drops, abort to IDLE with no write and no ack.
  - ACK: `ack_out` = 1 for exactly one cycle, then go to IDLE unconditionally.
    - Write: latched word is updated nibble-wise per latched `sel`, at the clock edge that leaves ACK.
    - Read: `data_out` = mem[idx] with unselected nibbles forced to 0.
- Aborts: `cyc_in` falling during ACK does not cancel the transfer.
- Data hold: `data_out` is 0 whenever `ack_out` = 0, and also during write acks.
- Back-to-back transfers: every transfer passes through IDLE. If `cyc_in` stays high in IDLE after an ack, that is a new transfer using the current inputs.
- Reset (any state, including mid-transfer): FSM goes to IDLE, counter to 0, `ack_out` = 0, `data_out` = 0, every memory word = 16'h0000. A pending write is dropped.

## Timing
- Inputs sampled high in IDLE at edge n → `ack_out` high in cycle n+1+`WAIT_STATES`, low again in the next cycle.
- Throughput: one transfer per `WAIT_STATES`+2 cycles.
- Read-after-write: a read accepted in the cycle after a write's ack returns the new data.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: `ack_out` = 0, `data_out` = 16'h0000.

## Structure
- Package `wb_pkg`:
  - constants `WB_ADR_W` = 16, `WB_DAT_W` = 16, `WB_SEL_W` = 4;
  - enum `wb_resp_state_t` {IDLE, WAIT, ACK};
  - function for nibble-mask expansion (4 → 16 bits).
- Sub-module `wb_mem_array`: flop storage with synchronous clear, one write port with 16-bit bit-mask and one combinational read port.
- Top level holds the FSM, decode, latches and counter.

## Test plan
- Reset, then read addr 5 with `sel` 4'hF → single ack, `data_out` 16'h0000.
- `WAIT_STATES` = 0: write 16'hA5C3 to addr 3 (`sel` F), then read addr 3 → ack one cycle after each request, read returns 16'hA5C3.
- Nibble enables: write 16'h1234 with `sel` F, then write 16'hFFFF with `sel` 4'b0101 → read returns 16'h1F3F.
- `WAIT_STATES` = 3: read request at edge n → `ack_out` only in cycle n+4, low in n+3 and n+5.
- Abort: `WAIT_STATES` = 3, write 16'hBEEF with `cyc_in` dropped after 2 cycles → no ack, and a later read returns the old value. Repeat with `reset` asserted in WAIT → no ack, memory reads 0.
- Decode miss: `BASE` = 16'h0100, `DEPTH` = 64, request at 16'h0200 held 20 cycles → `ack_out` never asserts. Request at 16'h013F → acked.
